// File: rtl/stepper_pkg.sv
// Shared definitions for the multi-axis stepper controller: FSM encoding, register map, CONTROL bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2,
        ST_DECEL  = 2'd3
    } axis_state_t;

    localparam logic [2:0] REG_CONTROL    = 3'd0;
    localparam logic [2:0] REG_POSITION   = 3'd1;
    localparam logic [2:0] REG_TARGET_DIV = 3'd2;
    localparam logic [2:0] REG_START_DIV  = 3'd3;
    localparam logic [2:0] REG_ACCEL      = 3'd4;
    localparam logic [2:0] REG_DISTANCE   = 3'd5;
    localparam logic [2:0] REG_STATUS     = 3'd6;
    localparam logic [2:0] REG_ID         = 3'd7;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_DIR  = 2;

    localparam logic [31:0] READ_DEFAULT = 32'h0000ABCD;

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: register file, IDLE/ACCEL/CRUISE/DECEL FSM, period counter and linear ramp.
// Latency: register writes take effect next clock; step rises the first clock after a start.
// Backpressure: none, writes are always accepted. Optional STEPPER_LIMIT_EN adds the lim_n end switch.
module stepper_axis
    import stepper_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int DEF_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_vld,
    input  logic [2:0]  wr_reg,
    input  logic [31:0] wr_dat,
    input  logic [2:0]  rd_reg,
    output logic [31:0] rd_dat,
    output logic        en,
    output logic        step,
    output logic        dir
`ifdef STEPPER_LIMIT_EN
    ,
    input  logic        lim_n
`endif
);
    localparam logic [31:0] PW_L      = 32'(PULSE_W);
    localparam logic [31:0] PER_MIN   = 32'(2 * PULSE_W);
    localparam logic [31:0] DEF_DIV_L = 32'(DEF_DIV);

    axis_state_t state_q, state_d;
    logic [31:0] cur_div_q, cur_div_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] ramp_steps_q, ramp_steps_d;
    logic [31:0] position_q, position_d;
    logic [31:0] target_div_q, target_div_d;
    logic [31:0] start_div_q, start_div_d;
    logic [31:0] accel_q, accel_d;
    logic [31:0] distance_q, distance_d;
    logic        mode_q, mode_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;
    logic        lim_hit_q, lim_hit_d;

    logic        moving, lim_low, step_evt, boundary, pulse_end;
    logic        wr_ctrl, start_req, stop_req, decel_due;
    logic [31:0] period, acc_div, dec_div;

`ifdef STEPPER_LIMIT_EN
    assign lim_low = ~lim_n;
`else
    assign lim_low = 1'b0;
`endif

    // Timing points within the current step period and saturating ramp targets
    always_comb begin
        moving    = (state_q != ST_IDLE);
        period    = (cur_div_q > PER_MIN) ? cur_div_q : PER_MIN;
        step_evt  = moving && (cnt_q == 32'd0);
        boundary  = moving && (cnt_q == period - 32'd1);
        pulse_end = moving && (cnt_q == PW_L - 32'd1);
        wr_ctrl   = wr_vld && (wr_reg == REG_CONTROL);
        start_req = wr_ctrl && wr_dat[CTRL_RUN] && !moving;
        stop_req  = wr_ctrl && !wr_dat[CTRL_RUN] && moving;
        decel_due = mode_q && (remaining_q <= ramp_steps_q);
        acc_div   = ((cur_div_q > target_div_q) && ((cur_div_q - target_div_q) > accel_q))
                    ? cur_div_q - accel_q : target_div_q;
        dec_div   = ((cur_div_q < start_div_q) && ((start_div_q - cur_div_q) > accel_q))
                    ? cur_div_q + accel_q : start_div_q;
    end

    // Register writes, start/stop handling and the per-step FSM
    always_comb begin
        state_d      = state_q;
        cur_div_d    = cur_div_q;
        cnt_d        = cnt_q;
        remaining_d  = remaining_q;
        ramp_steps_d = ramp_steps_q;
        position_d   = position_q;
        target_div_d = target_div_q;
        start_div_d  = start_div_q;
        accel_d      = accel_q;
        distance_d   = distance_q;
        mode_d       = mode_q;
        dir_d        = dir_q;
        done_d       = done_q;
        lim_hit_d    = lim_hit_q;

        if (wr_vld) begin
            case (wr_reg)
                REG_TARGET_DIV: target_div_d = wr_dat;
                REG_START_DIV:  start_div_d  = wr_dat;
                REG_ACCEL:      accel_d      = wr_dat;
                REG_DISTANCE:   distance_d   = wr_dat;
                default: ;
            endcase
        end

        if (!moving) begin
            cnt_d = 32'd0;
            // mode and dir only change while idle
            if (wr_ctrl) begin
                mode_d = wr_dat[CTRL_MODE];
                dir_d  = wr_dat[CTRL_DIR];
            end
            if (start_req && !lim_low) begin
                done_d       = 1'b0;
                lim_hit_d    = 1'b0;
                ramp_steps_d = 32'd0;
                remaining_d  = distance_q;
                if (wr_dat[CTRL_MODE] && (distance_q == 32'd0)) begin
                    done_d = 1'b1;
                end else if (accel_q == 32'd0) begin
                    // No ramp: run straight at the cruise period
                    cur_div_d = target_div_q;
                    state_d   = ST_CRUISE;
                end else begin
                    cur_div_d = start_div_q;
                    state_d   = ST_ACCEL;
                end
            end
        end else begin
            cnt_d = boundary ? 32'd0 : cnt_q + 32'd1;
            if (step_evt) begin
                position_d = dir_q ? position_q + 32'd1 : position_q - 32'd1;
                if (mode_q) begin
                    remaining_d = remaining_q - 32'd1;
                end
                if (state_q == ST_ACCEL) begin
                    ramp_steps_d = ramp_steps_q + 32'd1;
                end
            end
            // Period changes only at the end of a step period
            if (boundary) begin
                case (state_q)
                    ST_ACCEL: begin
                        if (decel_due) begin
                            state_d   = ST_DECEL;
                            cur_div_d = dec_div;
                        end else begin
                            cur_div_d = acc_div;
                            if (acc_div == target_div_q) begin
                                state_d = ST_CRUISE;
                            end
                        end
                    end
                    ST_CRUISE: begin
                        if (decel_due) begin
                            state_d   = ST_DECEL;
                            cur_div_d = dec_div;
                        end else begin
                            cur_div_d = target_div_q;
                        end
                    end
                    default: cur_div_d = dec_div;
                endcase
            end
            // Finish once the last pulse has had its full high time
            if (mode_q && pulse_end && (remaining_d == 32'd0)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            if (stop_req) begin
                state_d = ST_IDLE;
            end
            if (lim_low) begin
                state_d   = ST_IDLE;
                lim_hit_d = 1'b1;
            end
            if (state_d == ST_IDLE) begin
                cnt_d = 32'd0;
            end
        end

        // A clear request wins over a step in the same clock
        if (wr_vld && (wr_reg == REG_POSITION) && wr_dat[0]) begin
            position_d = 32'd0;
        end
    end

    // State and register flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_div_q    <= DEF_DIV_L;
            cnt_q        <= 32'd0;
            remaining_q  <= 32'd0;
            ramp_steps_q <= 32'd0;
            position_q   <= 32'd0;
            target_div_q <= DEF_DIV_L;
            start_div_q  <= DEF_DIV_L;
            accel_q      <= 32'd0;
            distance_q   <= 32'd0;
            mode_q       <= 1'b0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            lim_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_div_q    <= cur_div_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            ramp_steps_q <= ramp_steps_d;
            position_q   <= position_d;
            target_div_q <= target_div_d;
            start_div_q  <= start_div_d;
            accel_q      <= accel_d;
            distance_q   <= distance_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            lim_hit_q    <= lim_hit_d;
        end
    end

    assign en   = moving;
    assign step = moving && (cnt_q < PW_L);
    assign dir  = dir_q;

    // Register read mux; run bit reads back as the live busy flag
    always_comb begin
        rd_dat = READ_DEFAULT;
        case (rd_reg)
            REG_CONTROL:    rd_dat = {29'd0, dir_q, mode_q, moving};
            REG_POSITION:   rd_dat = position_q;
            REG_TARGET_DIV: rd_dat = target_div_q;
            REG_START_DIV:  rd_dat = start_div_q;
            REG_ACCEL:      rd_dat = accel_q;
            REG_DISTANCE:   rd_dat = distance_q;
            REG_STATUS:     rd_dat = {28'd0, lim_hit_q, (state_q == ST_DECEL), done_q, moving};
            REG_ID:         rd_dat = READ_DEFAULT;
            default:        rd_dat = READ_DEFAULT;
        endcase
    end

endmodule

// File: rtl/stepper_multi_axis_ctrl.sv
// Avalon-MM slave with N_AXES step/dir/enable channels; address = {axis index, register[2:0]}.
// Latency: readdata registered, valid 1 clock after cs&read; writes land the next clock.
// Backpressure: none (no waitrequest). Optional STEPPER_LIMIT_EN adds lim_n[N_AXES-1:0].
module stepper_multi_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int N_AXES  = 2,
    parameter int PULSE_W = 4,
    parameter int DEF_DIV = 100000
) (
    input  logic                        avs_clk,
    input  logic                        avs_reset_n,
    input  logic                        avs_cs,
    input  logic [$clog2(N_AXES)+2:0]   avs_address,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    input  logic                        avs_read,
    output logic [31:0]                 avs_readdata,
    output logic [N_AXES-1:0]           en,
    output logic [N_AXES-1:0]           step,
    output logic [N_AXES-1:0]           dir
`ifdef STEPPER_LIMIT_EN
    ,
    input  logic [N_AXES-1:0]           lim_n
`endif
);
    localparam int AW = $clog2(N_AXES) + 3;

    logic [AW-1:0] axis_sel;
    logic [2:0]    reg_sel;
    logic [31:0]   axis_rd [N_AXES];
    logic [31:0]   readdata_q, readdata_d;

    assign axis_sel = avs_address >> 3;
    assign reg_sel  = avs_address[2:0];

    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        logic wr_vld_i;
        assign wr_vld_i = avs_cs && avs_write && (axis_sel == AW'(i));

        stepper_axis #(
            .PULSE_W (PULSE_W),
            .DEF_DIV (DEF_DIV)
        ) u_axis (
            .clk    (avs_clk),
            .rst_n  (avs_reset_n),
            .wr_vld (wr_vld_i),
            .wr_reg (reg_sel),
            .wr_dat (avs_writedata),
            .rd_reg (reg_sel),
            .rd_dat (axis_rd[i]),
            .en     (en[i]),
            .step   (step[i]),
            .dir    (dir[i])
`ifdef STEPPER_LIMIT_EN
            ,
            .lim_n  (lim_n[i])
`endif
        );
    end

    // Select the addressed axis; indices beyond N_AXES read the default pattern
    always_comb begin
        readdata_d = readdata_q;
        if (avs_cs && avs_read) begin
            readdata_d = READ_DEFAULT;
            for (int i = 0; i < N_AXES; i++) begin
                if (axis_sel == AW'(i)) begin
                    readdata_d = axis_rd[i];
                end
            end
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge avs_clk) begin
        if (!avs_reset_n) begin
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_stepper_multi_axis_ctrl.sv
// Directed bench for stepper_multi_axis_ctrl: register table, ramp profile, unlimited run/stop,
// zero-distance start, reset mid-move and (with STEPPER_LIMIT_EN) the end switch.
// Timing: inputs driven on falling edges, outputs sampled on falling edges.
module tb_stepper_multi_axis_ctrl;

    localparam int AW = $clog2(2) + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          avs_cs = 1'b0;
    logic [AW-1:0] avs_address = '0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic          avs_read = 1'b0;
    logic [31:0]   avs_readdata;
    logic [1:0]    en, step, dir;
`ifdef STEPPER_LIMIT_EN
    logic [1:0]    lim_n = 2'b11;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stepper_multi_axis_ctrl #(.N_AXES(2), .PULSE_W(4), .DEF_DIV(100000)) dut (
        .avs_clk       (clk),
        .avs_reset_n   (rst_n),
        .avs_cs        (avs_cs),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .en            (en),
        .step          (step),
        .dir           (dir)
`ifdef STEPPER_LIMIT_EN
        ,
        .lim_n         (lim_n)
`endif
    );

    typedef struct {
        bit          wr;
        int          ax;
        logic [2:0]  rg;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];
    int   exp_per[19];
    int   meas[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input int ax, input logic [2:0] rg, input logic [31:0] data);
        @(negedge clk);
        avs_cs        = 1'b1;
        avs_write     = 1'b1;
        avs_address   = AW'((ax << 3) | int'(rg));
        avs_writedata = data;
        @(negedge clk);
        avs_cs    = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input int ax, input logic [2:0] rg, output logic [31:0] data);
        @(negedge clk);
        avs_cs      = 1'b1;
        avs_read    = 1'b1;
        avs_address = AW'((ax << 3) | int'(rg));
        @(negedge clk);
        data     = avs_readdata;
        avs_cs   = 1'b0;
        avs_read = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int rises, last_rise, hi, last_hi, fell, step_no_en, any_step;
        logic prev;

        vecs[0]  = '{1'b0, 0, 3'd2, 32'd0,   32'd100000,   "rst_tdiv0"};
        vecs[1]  = '{1'b0, 0, 3'd3, 32'd0,   32'd100000,   "rst_sdiv0"};
        vecs[2]  = '{1'b0, 1, 3'd6, 32'd0,   32'd0,        "rst_status1"};
        vecs[3]  = '{1'b0, 1, 3'd0, 32'd0,   32'd0,        "rst_control1"};
        vecs[4]  = '{1'b0, 0, 3'd1, 32'd0,   32'd0,        "rst_pos0"};
        vecs[5]  = '{1'b0, 0, 3'd7, 32'd0,   32'h0000ABCD, "id0"};
        vecs[6]  = '{1'b1, 0, 3'd3, 32'd40,  32'd40,       "wr_sdiv0"};
        vecs[7]  = '{1'b1, 0, 3'd2, 32'd10,  32'd10,       "wr_tdiv0"};
        vecs[8]  = '{1'b1, 0, 3'd4, 32'd10,  32'd10,       "wr_accel0"};
        vecs[9]  = '{1'b1, 0, 3'd5, 32'd20,  32'd20,       "wr_dist0"};
        vecs[10] = '{1'b1, 1, 3'd2, 32'd8,   32'd8,        "wr_tdiv1"};
        vecs[11] = '{1'b1, 1, 3'd5, 32'd123, 32'd123,      "wr_dist1"};

        // 40,30,20 ramp, 14 cruise steps at 10, then 20,30 (last 40 period has no following rise)
        exp_per[0] = 40; exp_per[1] = 30; exp_per[2] = 20;
        for (int i = 3; i < 17; i++) exp_per[i] = 10;
        exp_per[17] = 20; exp_per[18] = 30;
        for (int i = 0; i < 19; i++) meas[i] = -1;

        repeat (3) @(negedge clk);
        check("rst_en", 32'(en), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].ax, vecs[i].rg, vecs[i].wd);
            bus_read(vecs[i].ax, vecs[i].rg, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // Limited ramp on axis 0, dir=1
        bus_write(0, 3'd0, 32'h7);
        prev = 1'b0; rises = 0; last_rise = 0; hi = 0; last_hi = 0; fell = 0; step_no_en = 0;
        for (int c = 0; c < 800; c++) begin
            if (step[0] && !prev) begin
                if (rises > 0 && rises < 20) meas[rises-1] = c - last_rise;
                last_rise = c;
                rises++;
                hi = 0;
            end
            if (step[0]) hi++;
            else if (prev) last_hi = hi;
            if (step[0] && !en[0]) step_no_en = 1;
            if (rises > 0 && !en[0]) begin
                fell = 1;
                break;
            end
            prev = step[0];
            @(negedge clk);
        end
        check("ramp_en_fell", 32'(fell), 32'd1);
        check("ramp_pulses", 32'(rises), 32'd20);
        check("ramp_last_pulse_w", 32'(last_hi), 32'd4);
        check("ramp_step_without_en", 32'(step_no_en), 32'd0);
        for (int i = 0; i < 19; i++) check($sformatf("ramp_per%0d", i), 32'(meas[i]), 32'(exp_per[i]));
        bus_read(0, 3'd1, rd);
        check("ramp_pos", rd, 32'd20);
        bus_read(0, 3'd6, rd);
        check("ramp_status", rd, 32'h2);

        // Unlimited run on axis 1, ACCEL=0, TARGET=8, dir=0
        bus_write(1, 3'd0, 32'h1);
        prev = 1'b0; rises = 0; last_rise = 0;
        for (int c = 0; c < 36; c++) begin
            if (step[1] && !prev) begin
                if (rises > 0) check($sformatf("unl_per%0d", rises), 32'(c - last_rise), 32'd8);
                last_rise = c;
                rises++;
            end
            prev = step[1];
            @(negedge clk);
        end
        check("unl_rises", 32'(rises), 32'd5);
        check("unl_dir", 32'(dir[1]), 32'd0);
        bus_write(1, 3'd0, 32'h0);
        check("stop_en", 32'(en[1]), 32'd0);
        check("stop_step", 32'(step[1]), 32'd0);
        bus_read(1, 3'd6, rd);
        check("stop_status", rd, 32'h0);
        bus_read(1, 3'd1, rd);
        check("unl_pos", rd, 32'hFFFF_FFFB);

        // Limited with DISTANCE=0: stays idle, done set
        bus_write(1, 3'd5, 32'd0);
        bus_write(1, 3'd0, 32'h3);
        check("dist0_en", 32'(en[1]), 32'd0);
        any_step = 0;
        for (int c = 0; c < 20; c++) begin
            if (step[1] || en[1]) any_step = 1;
            @(negedge clk);
        end
        check("dist0_no_step", 32'(any_step), 32'd0);
        bus_read(1, 3'd6, rd);
        check("dist0_status", rd, 32'h2);

        // Both axes running, then a one-clock reset
        bus_write(0, 3'd0, 32'h1);
        bus_write(1, 3'd0, 32'h1);
        repeat (30) @(negedge clk);
        check("both_en", 32'(en), 32'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_en", 32'(en), 32'd0);
        check("rst_mid_step", 32'(step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(0, 3'd2, rd);
        check("rst_mid_tdiv0", rd, 32'd100000);
        bus_read(0, 3'd1, rd);
        check("rst_mid_pos0", rd, 32'd0);
        bus_read(1, 3'd4, rd);
        check("rst_mid_accel1", rd, 32'd0);
        bus_read(1, 3'd0, rd);
        check("rst_mid_ctrl1", rd, 32'd0);

`ifdef STEPPER_LIMIT_EN
        bus_write(0, 3'd2, 32'd8);
        bus_write(0, 3'd0, 32'h1);
        repeat (10) @(negedge clk);
        check("lim_pre_en", 32'(en[0]), 32'd1);
        lim_n[0] = 1'b0;
        @(negedge clk);
        check("lim_en", 32'(en[0]), 32'd0);
        bus_read(0, 3'd6, rd);
        check("lim_status", rd, 32'h8);
        bus_write(0, 3'd0, 32'h1);
        check("lim_refused_en", 32'(en[0]), 32'd0);
        bus_read(0, 3'd6, rd);
        check("lim_refused_status", rd, 32'h8);
        lim_n[0] = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
